// File: rtl/ln_pkg.sv
// ---------------------------------------------------------------------------
// ln_pkg
// Shared widths and types for the LayerNorm stage-2 row reducer.
//   NUM_CHUNKS  chunks of 64 elements that make up one row
//   PTR_W       row-slot pointer width (NUM_SLOTS = 2**PTR_W)
//   CNT_W       chunk counter width
//   PSUM_W      signed partial-sum width coming from stage 1
//   PSQ_W       signed partial square-sum width coming from stage 1
//   FIFO_DEPTH  output FIFO entries (power of two)
//   SUM_W/SQ_W  full-row widths, grown by $clog2(NUM_CHUNKS) guard bits
// Optional feature macro: LN_MEAN_EN adds RECIP_Q16 and a mean field to the
// FIFO entry.
// ---------------------------------------------------------------------------
package ln_pkg;

    localparam int NUM_CHUNKS = 12;
    localparam int PTR_W      = 2;
    localparam int NUM_SLOTS  = 2 ** PTR_W;
    localparam int CNT_W      = 4;
    localparam int PSUM_W     = 22;
    localparam int PSQ_W      = 38;
    localparam int FIFO_DEPTH = 4;

    // Summing NUM_CHUNKS values needs $clog2(NUM_CHUNKS) extra bits of headroom
    function automatic int calcSumW(input int partW, input int numChunks);
        return partW + $clog2(numChunks);
    endfunction

    function automatic int calcSqW(input int partSqW, input int numChunks);
        return partSqW + $clog2(numChunks);
    endfunction

    localparam int SUM_W = calcSumW(PSUM_W, NUM_CHUNKS);
    localparam int SQ_W  = calcSqW(PSQ_W, NUM_CHUNKS);

`ifdef LN_MEAN_EN
    // round(65536 / row width), the Q16 reciprocal used to turn a sum into a mean
    localparam int RECIP_Q16 = 85;
`endif

    typedef struct packed {
        logic [PTR_W-1:0]        ptr;
        logic signed [SUM_W-1:0] sum;
        logic signed [SQ_W-1:0]  sqSum;
`ifdef LN_MEAN_EN
        logic signed [SUM_W-1:0] mean;
`endif
    } ln_row_stat_t;

endpackage

// File: rtl/ln_stat_fifo.sv
// ---------------------------------------------------------------------------
// ln_stat_fifo
// Small synchronous FIFO of completed-row statistics with a registered head.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push, i_data  write request and entry; ignored when full unless a pop
//                   happens in the same cycle
//   i_pop           remove the head (ignored when empty)
//   o_valid         head register holds a live entry
//   o_full          all DEPTH entries occupied
//   o_data          registered head entry, stable until the next pop
// ---------------------------------------------------------------------------
module ln_stat_fifo
    import ln_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
)
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  ln_row_stat_t i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic         o_full,
    output ln_row_stat_t o_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ln_row_stat_t  r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_countAfterPop;
    logic [CW-1:0] w_nextCount;
    logic [AW-1:0] w_nextRdPtr;

    assign o_full = (r_count == CW'(DEPTH));

    // A push into a full FIFO only succeeds when the head leaves in the same cycle
    always_comb begin
        w_pop           = i_pop && (r_count != '0);
        w_push          = i_push && (!o_full || w_pop);
        w_countAfterPop = r_count - CW'(w_pop);
        w_nextCount     = w_countAfterPop + CW'(w_push);
        w_nextRdPtr     = r_rdPtr + AW'(w_pop);
    end

    // Storage array; written only on an accepted push
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers, occupancy and the registered head. When the FIFO drains to
    // nothing before this cycle's push, the new head bypasses the array
    // because it is being written at this very edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            r_rdPtr <= w_nextRdPtr;
            r_count <= w_nextCount;
            o_valid <= (w_nextCount != '0);
            if (w_nextCount != '0) begin
                o_data <= (w_countAfterPop == '0) ? i_data : r_mem[w_nextRdPtr];
            end
        end
    end

endmodule

// File: rtl/ln_stage2_row_reduce.sv
// ---------------------------------------------------------------------------
// ln_stage2_row_reduce
// LayerNorm stage 2: accumulates per-slot partial sums / square-sums over
// NUM_CHUNKS chunks and queues each completed row for stage 3.
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_en                accumulate-side enable (output side always runs)
//   i_acc_valid         partial-sum valid
//   i_acc_ptr           row slot, i_acc_cnt chunk index within the row
//   i_part_sum          signed partial sum, i_part_sq_sum signed square-sum
//   o_valid / i_ready   output handshake, pop on o_valid && i_ready
//   o_ptr, o_sum, o_sq_sum  completed row, stable while stalled
//   o_mean              (LN_MEAN_EN only) rounded row mean
//   o_overflow          sticky: row completed while the FIFO was full
//   o_seq_err           sticky: out-of-order chunk counter seen
// Optional feature macro: LN_MEAN_EN.
// ---------------------------------------------------------------------------
module ln_stage2_row_reduce
    import ln_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_acc_valid,
    input  logic [PTR_W-1:0]         i_acc_ptr,
    input  logic [CNT_W-1:0]         i_acc_cnt,
    input  logic signed [PSUM_W-1:0] i_part_sum,
    input  logic signed [PSQ_W-1:0]  i_part_sq_sum,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [PTR_W-1:0]         o_ptr,
    output logic signed [SUM_W-1:0]  o_sum,
    output logic signed [SQ_W-1:0]   o_sq_sum,
`ifdef LN_MEAN_EN
    output logic signed [SUM_W-1:0]  o_mean,
`endif
    output logic                     o_overflow,
    output logic                     o_seq_err
);

    logic signed [SUM_W-1:0] r_sumAcc [NUM_SLOTS];
    logic signed [SQ_W-1:0]  r_sqAcc  [NUM_SLOTS];
    logic [CNT_W-1:0]        r_expCnt [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    r_poison;
    logic                    r_overflow;
    logic                    r_seqErr;

    logic                    w_accept;
    logic                    w_isStart;
    logic                    w_match;
    logic                    w_isLast;
    logic                    w_complete;
    logic                    w_seqErr;
    logic                    w_pop;
    logic                    w_fifoFull;
    logic signed [SUM_W-1:0] w_partExt;
    logic signed [SQ_W-1:0]  w_partSqExt;
    logic signed [SUM_W-1:0] w_newSum;
    logic signed [SQ_W-1:0]  w_newSq;
    ln_row_stat_t            w_pushEntry;
    ln_row_stat_t            w_headEntry;

`ifdef LN_MEAN_EN
    // RECIP_Q16 fits in 8 bits; one more bit keeps the rounding add safe
    localparam int MEAN_PROD_W = SUM_W + 9;
    logic signed [MEAN_PROD_W-1:0] w_meanProd;
`endif

    // Decode the incoming chunk against the slot's expected counter. Counter
    // values at or beyond NUM_CHUNKS can never equal the expected counter, so
    // they fall out as sequence errors without a separate range check.
    always_comb begin
        w_accept    = i_en && i_acc_valid;
        w_isStart   = (i_acc_cnt == '0);
        w_match     = (i_acc_cnt == r_expCnt[i_acc_ptr]);
        w_isLast    = (i_acc_cnt == CNT_W'(NUM_CHUNKS - 1));
        w_complete  = w_accept && !w_isStart && w_match && w_isLast && !r_poison[i_acc_ptr];
        w_seqErr    = w_accept && !w_isStart && !w_match;
        w_partExt   = {{(SUM_W - PSUM_W){i_part_sum[PSUM_W-1]}}, i_part_sum};
        w_partSqExt = {{(SQ_W - PSQ_W){i_part_sq_sum[PSQ_W-1]}}, i_part_sq_sum};
        w_newSum    = r_sumAcc[i_acc_ptr] + w_partExt;
        w_newSq     = r_sqAcc[i_acc_ptr] + w_partSqExt;
        w_pop       = o_valid && i_ready;
    end

    // Build the FIFO entry for a completing row, including the rounded mean
    // when that feature is compiled in
    always_comb begin
        w_pushEntry       = '0;
        w_pushEntry.ptr   = i_acc_ptr;
        w_pushEntry.sum   = w_newSum;
        w_pushEntry.sqSum = w_newSq;
`ifdef LN_MEAN_EN
        w_meanProd       = MEAN_PROD_W'(w_newSum) * MEAN_PROD_W'(RECIP_Q16) + MEAN_PROD_W'(2 ** 15);
        w_pushEntry.mean = SUM_W'(w_meanProd >>> 16);
`endif
    end

    // Per-slot accumulators. A chunk 0 always restarts the slot; an in-order
    // chunk accumulates; anything else poisons the slot so its completion is
    // dropped. The counter wraps to 0 once the last chunk is matched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                r_sumAcc[s] <= '0;
                r_sqAcc[s]  <= '0;
                r_expCnt[s] <= '0;
            end
            r_poison <= '0;
        end else if (w_accept) begin
            if (w_isStart) begin
                r_sumAcc[i_acc_ptr] <= w_partExt;
                r_sqAcc[i_acc_ptr]  <= w_partSqExt;
                r_expCnt[i_acc_ptr] <= CNT_W'(1);
                r_poison[i_acc_ptr] <= 1'b0;
            end else if (w_match) begin
                r_sumAcc[i_acc_ptr] <= w_newSum;
                r_sqAcc[i_acc_ptr]  <= w_newSq;
                r_expCnt[i_acc_ptr] <= w_isLast ? '0 : r_expCnt[i_acc_ptr] + CNT_W'(1);
            end else begin
                r_poison[i_acc_ptr] <= 1'b1;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
            r_seqErr   <= 1'b0;
        end else begin
            if (w_complete && w_fifoFull && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_seqErr) begin
                r_seqErr <= 1'b1;
            end
        end
    end

    ln_stat_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_complete),
        .i_data  (w_pushEntry),
        .i_pop   (w_pop),
        .o_valid (o_valid),
        .o_full  (w_fifoFull),
        .o_data  (w_headEntry)
    );

    assign o_ptr      = w_headEntry.ptr;
    assign o_sum      = w_headEntry.sum;
    assign o_sq_sum   = w_headEntry.sqSum;
`ifdef LN_MEAN_EN
    assign o_mean     = w_headEntry.mean;
`endif
    assign o_overflow = r_overflow;
    assign o_seq_err  = r_seqErr;

endmodule

// File: tb/tb_ln_stage2_row_reduce.sv
// ---------------------------------------------------------------------------
// tb_ln_stage2_row_reduce
// Directed bench for the stage-2 row reducer. Inputs change and outputs are
// sampled on the falling clock edge, half a period away from the capturing
// rising edge. Build with LN_MEAN_EN defined to also exercise o_mean.
// ---------------------------------------------------------------------------
module tb_ln_stage2_row_reduce;
    import ln_pkg::*;

    logic                     i_clk;
    logic                     i_rst_n;
    logic                     i_en;
    logic                     i_acc_valid;
    logic [PTR_W-1:0]         i_acc_ptr;
    logic [CNT_W-1:0]         i_acc_cnt;
    logic signed [PSUM_W-1:0] i_part_sum;
    logic signed [PSQ_W-1:0]  i_part_sq_sum;
    logic                     o_valid;
    logic                     i_ready;
    logic [PTR_W-1:0]         o_ptr;
    logic signed [SUM_W-1:0]  o_sum;
    logic signed [SQ_W-1:0]   o_sq_sum;
`ifdef LN_MEAN_EN
    logic signed [SUM_W-1:0]  o_mean;
`endif
    logic                     o_overflow;
    logic                     o_seq_err;

    int testCount = 0;
    int failCount = 0;
    int stallCount = 0;

    ln_stage2_row_reduce dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (i_en),
        .i_acc_valid   (i_acc_valid),
        .i_acc_ptr     (i_acc_ptr),
        .i_acc_cnt     (i_acc_cnt),
        .i_part_sum    (i_part_sum),
        .i_part_sq_sum (i_part_sq_sum),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_ptr         (o_ptr),
        .o_sum         (o_sum),
        .o_sq_sum      (o_sq_sum),
`ifdef LN_MEAN_EN
        .o_mean        (o_mean),
`endif
        .o_overflow    (o_overflow),
        .o_seq_err     (o_seq_err)
    );

    // Free-running 10-time-unit clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Present one cycle of accumulate-side inputs, then wait for the falling
    // edge after the rising edge that captured them
    task automatic applyStimulus(input logic en, input logic valid, input logic [PTR_W-1:0] ptr,
                                 input logic [CNT_W-1:0] cnt, input logic signed [PSUM_W-1:0] part,
                                 input logic signed [PSQ_W-1:0] partSq);
        i_en          = en;
        i_acc_valid   = valid;
        i_acc_ptr     = ptr;
        i_acc_cnt     = cnt;
        i_part_sum    = part;
        i_part_sq_sum = partSq;
        @(negedge i_clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, '0, '0, '0, '0);
    endtask

    // Send one chunk; optionally precede it with an enable-low cycle carrying
    // junk data that must be ignored
    task automatic sendChunk(input logic [PTR_W-1:0] ptr, input logic [CNT_W-1:0] cnt,
                             input logic signed [PSUM_W-1:0] part, input logic signed [PSQ_W-1:0] partSq,
                             input bit stallFirst);
        if (stallFirst) begin
            applyStimulus(1'b0, 1'b1, ptr, cnt, 22'sd1000, 38'sd1000);
        end
        applyStimulus(1'b1, 1'b1, ptr, cnt, part, partSq);
    endtask

    // Send a full clean row of identical chunks
    task automatic sendRow(input logic [PTR_W-1:0] ptr, input logic signed [PSUM_W-1:0] part,
                           input logic signed [PSQ_W-1:0] partSq);
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            sendChunk(ptr, CNT_W'(c), part, partSq, 1'b0);
        end
    endtask

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkRow(input string tag, input logic [PTR_W-1:0] ptr, input logic signed [63:0] sum,
                            input logic signed [63:0] sqSum);
        checkOutput({tag, "_valid"}, o_valid, 1);
        checkOutput({tag, "_ptr"}, o_ptr, ptr);
        checkOutput({tag, "_sum"}, o_sum, sum);
        checkOutput({tag, "_sq"}, o_sq_sum, sqSum);
    endtask

    // Directed test sequence
    initial begin
        i_rst_n = 1'b0;
        i_ready = 1'b1;
        i_en = 1'b1;
        i_acc_valid = 1'b0;
        i_acc_ptr = '0;
        i_acc_cnt = '0;
        i_part_sum = '0;
        i_part_sq_sum = '0;
        repeat (3) @(negedge i_clk);

        // Reset state
        checkOutput("rst_valid", o_valid, 0);
        checkOutput("rst_sum", o_sum, 0);
        checkOutput("rst_overflow", o_overflow, 0);
        checkOutput("rst_seq_err", o_seq_err, 0);
        i_rst_n = 1'b1;
        idleCycle();

        // Single row on slot 0, result one cycle after the last chunk
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            sendChunk(2'd0, CNT_W'(c), 22'sd1, 38'sd2, 1'b0);
            if (c == NUM_CHUNKS - 2) checkOutput("row0_early_valid", o_valid, 0);
        end
        checkRow("row0", 2'd0, 12, 24);
`ifdef LN_MEAN_EN
        checkOutput("row0_mean", o_mean, 0);
`endif
        idleCycle();
        checkOutput("row0_pulse_end", o_valid, 0);

        // Most-negative partial sum on every chunk
        sendRow(2'd1, -22'sd2097152, 38'sd5);
        checkRow("neg", 2'd1, -25165824, 60);
        idleCycle();

`ifdef LN_MEAN_EN
        sendRow(2'd0, 22'sd64, 38'sd1);
        checkOutput("mean_768", o_mean, 1);
        idleCycle();
`endif

        // Slots 1 and 2 interleaved, enable dropping every third chunk
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            sendChunk(2'd1, CNT_W'(c), PSUM_W'(c + 1), 38'sd3, (stallCount % 3) == 2);
            stallCount++;
            if (c == NUM_CHUNKS - 1) checkRow("ilv_p1", 2'd1, 78, 36);
            sendChunk(2'd2, CNT_W'(c), -22'sd5, 38'sd100, (stallCount % 3) == 2);
            stallCount++;
        end
        checkRow("ilv_p2", 2'd2, -60, 1200);
        idleCycle();
        checkOutput("ilv_drained", o_valid, 0);

        // Backpressure: five rows into a four-entry FIFO
        i_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            sendRow(PTR_W'(r % 4), PSUM_W'(r + 1), PSQ_W'(r + 2));
            if (r == 3) checkOutput("bp_no_ovf_yet", o_overflow, 0);
        end
        checkRow("bp_head_stable", 2'd0, 12, 24);
        checkOutput("bp_overflow", o_overflow, 1);
        i_ready = 1'b1;
        for (int r = 1; r < 4; r++) begin
            idleCycle();
            checkRow($sformatf("bp_drain%0d", r), PTR_W'(r), 12 * (r + 1), 12 * (r + 2));
        end
        idleCycle();
        checkOutput("bp_fifth_absent", o_valid, 0);

        // Sequence error on slot 3 (chunk 2 skipped), then a clean row there
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (c != 2) sendChunk(2'd3, CNT_W'(c), 22'sd7, 38'sd7, 1'b0);
            if (c == 1) checkOutput("seq_before", o_seq_err, 0);
            if (c == 3) checkOutput("seq_flag", o_seq_err, 1);
        end
        checkOutput("seq_dropped", o_valid, 0);
        idleCycle();
        checkOutput("seq_dropped_late", o_valid, 0);
        sendRow(2'd3, 22'sd2, 38'sd4);
        checkRow("seq_clean", 2'd3, 24, 48);
        checkOutput("seq_sticky", o_seq_err, 1);
        idleCycle();

        // Asynchronous reset in the middle of a row and of a drain
        i_ready = 1'b0;
        sendRow(2'd2, 22'sd1, 38'sd1);
        sendRow(2'd2, 22'sd1, 38'sd1);
        for (int c = 0; c < 6; c++) sendChunk(2'd0, CNT_W'(c), 22'sd100, 38'sd100, 1'b0);
        i_ready = 1'b1;
        idleCycle();
        checkOutput("pre_rst_valid", o_valid, 1);
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", o_valid, 0);
        checkOutput("arst_ptr", o_ptr, 0);
        checkOutput("arst_sum", o_sum, 0);
        checkOutput("arst_sq", o_sq_sum, 0);
        checkOutput("arst_overflow", o_overflow, 0);
        checkOutput("arst_seq_err", o_seq_err, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        idleCycle();
        sendRow(2'd0, 22'sd3, 38'sd1);
        checkRow("post_rst", 2'd0, 36, 12);
        checkOutput("post_rst_seq_err", o_seq_err, 0);
        idleCycle();
        checkOutput("post_rst_drained", o_valid, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ln_stage2_row_reduce.md
Name: ln_stage2_row_reduce

Overview:
Second LayerNorm stage, directly downstream of the 64-lane partial-sum stage. Consumes one delayed partial sum and partial square-sum per cycle, tagged with a row-slot pointer and chunk counter. Accumulates these per slot across NUM_CHUNKS chunks and emits complete-row {ptr, sum, sq_sum} through a small output FIFO with a valid/ready handshake. Stage 3 (mean/variance) consumes the FIFO output.

Parameters:
NUM_CHUNKS, 12, chunks of 64 elements per row (768-wide row)
PTR_W, 2, slot pointer width; NUM_SLOTS = 2**PTR_W
CNT_W, 4, chunk counter width
PSUM_W, 22, signed partial-sum width
PSQ_W, 38, signed partial-square-sum width
FIFO_DEPTH, 4, output FIFO entries (power of 2)
RECIP_Q16, 85, round(65536/(NUM_CHUNKS*64)); used only with LN_MEAN_EN

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  accumulate-side clock enable
i_acc_valid  in  1  partial-sum valid
i_acc_ptr  in  PTR_W  row slot
i_acc_cnt  in  CNT_W  chunk index within row
i_part_sum  in  PSUM_W  signed partial sum
i_part_sq_sum  in  PSQ_W  signed partial square-sum
o_valid  out  1  row result available
i_ready  in  1  downstream accepts
o_ptr  out  PTR_W  slot of emitted row
o_sum  out  SUM_W  row sum, SUM_W = PSUM_W + $clog2(NUM_CHUNKS)
o_sq_sum  out  SQ_W  row square-sum, SQ_W = PSQ_W + $clog2(NUM_CHUNKS)
o_overflow  out  1  sticky: row completed while FIFO full
o_seq_err  out  1  sticky: out-of-order chunk counter

Behaviour:
- Reset (async, i_rst_n low): slot accumulators, expected counters, and poison flags cleared. FIFO emptied. All outputs 0.
- Accept condition: i_en && i_acc_valid. With i_en low, accumulators and expected counters hold. The output/FIFO side keeps running regardless of i_en.
- Per slot s: accumulator sum[s] and sq[s] (sign-extended), exp_cnt[s], and poison[s].
- On accept with cnt==0: sum[s] <= sext(part), sq[s] <= sext(part_sq), exp_cnt <= 1, poison <= 0. A cnt==0 always restarts the row, even mid-row; this is not an error.
- On accept with cnt!=0 and cnt==exp_cnt: accumulate, exp_cnt++.
- On accept with cnt!=0 and cnt!=exp_cnt: set o_seq_err and poison[s]; the accumulator is not updated.
- Completion: accept with cnt==NUM_CHUNKS-1 and the slot not poisoned (after this cycle's check). Push {ptr, sum+part, sq+part_sq} into the FIFO at that edge. exp_cnt returns to 0.
- A poisoned row's completion is silently dropped.
- cnt values >= NUM_CHUNKS always mismatch and are treated as a sequence error.
- FIFO full at completion with no pop in the same cycle: entry dropped, o_overflow set. If a pop occurs in the same cycle, the push succeeds.
- Latency: completing chunk accepted at edge k → o_valid high after edge k when the FIFO was empty (1 cycle). Output data is registered from the FIFO head.
- Handshake: pop on o_valid && i_ready. o_ptr, o_sum, and o_sq_sum stay stable while o_valid && !i_ready. o_valid drops only after a pop that empties the FIFO.
- Sticky flags clear only on reset.
- Arithmetic is two's complement, sign-extended. Widths guarantee no internal overflow.

Optional Feature:
LN_MEAN_EN
- Defined: adds output o_mean (SUM_W, signed) = (o_sum * RECIP_Q16 + 2**15) >>> 16, computed at push time and stored in the FIFO entry. Handshake and latency are unchanged.
- Undefined: no o_mean port, no multiplier, and the FIFO entry width is reduced.

Decomposition:
- Package ln_pkg: PSUM_W, PSQ_W, CNT_W, PTR_W defaults; SUM_W/SQ_W derivation functions; the packed FIFO entry typedef ln_row_stat_t {ptr, sum, sq_sum[, mean]}.
- One sub-module: ln_stat_fifo, a synchronous FIFO with full/empty, simultaneous push/pop, and registered head.

Test Plan:
- Single row, ptr 0: parts 1 and sq 2 for cnt 0..11, i_ready=1 → one o_valid pulse one cycle after cnt 11, with o_sum=12, o_sq_sum=24, o_ptr=0.
- Negative values: part_sum=-2097152 for all 12 chunks → o_sum=-25165824, sign correct. With LN_MEAN_EN and sum=768 → o_mean=1.
- Interleave ptr 1 and ptr 2 chunk-by-chunk, i_en toggling low every third cycle → two correct results in completion order, with no corruption from stalled cycles.
- Backpressure: i_ready=0 while 5 rows complete → FIFO holds 4 stable entries and o_overflow=1. Then i_ready=1 → the 4 rows drain in order and the 5th is absent.
- Sequence error: ptr 3 cnt 0,1,3,...,11 → o_seq_err=1 and no output for that row. A following clean row on ptr 3 outputs correctly.
- Async reset asserted mid-row and mid-drain → all outputs 0 immediately. A fresh row after release gives the correct sum, with no stale data.
